// File: rtl/rf_scoreboard.sv
// Register file with per-register pending-write scoreboard: two async read ports,
// one sync write port, issue-time reservation. Optional forwarding: RF_BYPASS_EN.
module rf_scoreboard_cell #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 write_hit,
  input  logic                 reserve_hit,
  input  logic                 flush,
  input  logic [WORD_SIZE-1:0] data_w,
  output logic [WORD_SIZE-1:0] data,
  output logic                 busy,
  output logic                 busy_nxt
);
  // Reservation outranks both writeback release and flush; the shared
  // reserve_ok gate already keeps a flush-cycle reservation from reaching here.
  always_comb begin
    busy_nxt = busy;
    if (reserve_hit)    busy_nxt = 1'b1;
    else if (flush)     busy_nxt = 1'b0;
    else if (write_hit) busy_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      if (write_hit) data <= data_w;
      busy <= busy_nxt;
    end
  end
endmodule

module rf_scoreboard #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [ADDR_W-1:0]    addr2,
  output logic [WORD_SIZE-1:0] data1,
  output logic [WORD_SIZE-1:0] data2,
  output logic                 busy1,
  output logic                 busy2,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    addr_w,
  input  logic [WORD_SIZE-1:0] data_w,
  input  logic                 reserve,
  input  logic [ADDR_W-1:0]    addr_r,
  output logic                 reserve_ok,
  input  logic                 flush,
  output logic [ADDR_W:0]      busy_count
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int CW       = ADDR_W + 1;

  logic [NUM_REGS-1:0][WORD_SIZE-1:0] rf;
  logic [NUM_REGS-1:0]                busy, busy_nxt;

  // A same-cycle writeback to the target frees it, so the new producer may claim it.
  assign reserve_ok = reserve & (~busy[addr_r] | (write & (addr_w == addr_r))) & ~flush;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    rf_scoreboard_cell #(.WORD_SIZE(WORD_SIZE)) u_cell (
      .clk         (clk),
      .reset_n     (reset_n),
      .write_hit   (write && (addr_w == ADDR_W'(g))),
      .reserve_hit (reserve_ok && (addr_r == ADDR_W'(g))),
      .flush       (flush),
      .data_w      (data_w),
      .data        (rf[g]),
      .busy        (busy[g]),
      .busy_nxt    (busy_nxt[g])
    );
  end

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  // Counting the next-state vector keeps busy_count aligned with busy after each edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_count <= '0;
    else          busy_count <= popcount(busy_nxt);
  end

`ifdef RF_BYPASS_EN
  logic fwd1, fwd2;
  assign fwd1  = reset_n & write & (addr_w == addr1);
  assign fwd2  = reset_n & write & (addr_w == addr2);
  assign data1 = fwd1 ? data_w : rf[addr1];
  assign data2 = fwd2 ? data_w : rf[addr2];
  assign busy1 = fwd1 ? (reserve_ok & (addr_r == addr1)) : busy[addr1];
  assign busy2 = fwd2 ? (reserve_ok & (addr_r == addr2)) : busy[addr2];
`else
  assign data1 = rf[addr1];
  assign data2 = rf[addr2];
  assign busy1 = busy[addr1];
  assign busy2 = busy[addr2];
`endif
endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: vector table through a scoreboard queue,
// plus hand sequences for forwarding and mid-operation async reset.
module tb_rf_scoreboard;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr1, addr2, addr_w, addr_r;
  logic [15:0] data1, data2, data_w;
  logic        busy1, busy2, write, reserve, reserve_ok, flush;
  logic [2:0]  busy_count;

  int checks = 0;
  int errors = 0;

  rf_scoreboard #(.WORD_SIZE(16), .ADDR_W(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
    .busy1(busy1), .busy2(busy2),
    .write(write), .addr_w(addr_w), .data_w(data_w),
    .reserve(reserve), .addr_r(addr_r), .reserve_ok(reserve_ok),
    .flush(flush), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  aw;
    logic [15:0] dw;
    logic        rs;
    logic [1:0]  ar;
    logic        fl;
    logic [1:0]  a1;
    logic [1:0]  a2;
    logic        ok;
    logic [15:0] d1;
    logic        b1;
    logic [15:0] d2;
    logic        b2;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];
  vec_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //            wr aw  dw       rs ar fl a1 a2  ok  d1       b1 d2       b2 cnt
    vecs[0]  = '{0, 0, 16'h0000, 1, 2, 0, 2, 0,  1, 16'h0000, 1, 16'h0000, 0, 3'd1};
    vecs[1]  = '{1, 2, 16'hBEEF, 0, 0, 0, 2, 2,  0, 16'hBEEF, 0, 16'hBEEF, 0, 3'd0};
    vecs[2]  = '{0, 0, 16'h0000, 1, 1, 0, 1, 2,  1, 16'h0000, 1, 16'hBEEF, 0, 3'd1};
    vecs[3]  = '{0, 0, 16'h0000, 1, 1, 0, 1, 2,  0, 16'h0000, 1, 16'hBEEF, 0, 3'd1};
    vecs[4]  = '{1, 3, 16'h1234, 1, 3, 0, 3, 1,  1, 16'h1234, 1, 16'h0000, 1, 3'd2};
    vecs[5]  = '{1, 3, 16'h5678, 1, 3, 0, 3, 0,  1, 16'h5678, 1, 16'h0000, 0, 3'd2};
    vecs[6]  = '{1, 1, 16'h1111, 1, 0, 0, 1, 0,  1, 16'h1111, 0, 16'h0000, 1, 3'd2};
    vecs[7]  = '{0, 0, 16'h0000, 1, 1, 0, 1, 3,  1, 16'h1111, 1, 16'h5678, 1, 3'd3};
    vecs[8]  = '{1, 0, 16'h0F0F, 1, 2, 1, 0, 2,  0, 16'h0F0F, 0, 16'hBEEF, 0, 3'd0};
    vecs[9]  = '{1, 2, 16'hCAFE, 0, 0, 0, 2, 1,  0, 16'hCAFE, 0, 16'h1111, 0, 3'd0};
    vecs[10] = '{0, 0, 16'h0000, 1, 0, 0, 0, 3,  1, 16'h0F0F, 1, 16'h5678, 0, 3'd1};
    vecs[11] = '{0, 0, 16'h0000, 1, 1, 0, 1, 2,  1, 16'h1111, 1, 16'hCAFE, 0, 3'd2};
    vecs[12] = '{0, 0, 16'h0000, 1, 2, 0, 2, 3,  1, 16'hCAFE, 1, 16'h5678, 0, 3'd3};
    vecs[13] = '{0, 0, 16'h0000, 1, 3, 0, 3, 0,  1, 16'h5678, 1, 16'h0F0F, 1, 3'd4};
    vecs[14] = '{1, 0, 16'h0001, 1, 0, 0, 0, 1,  1, 16'h0001, 1, 16'h1111, 1, 3'd4};
    vecs[15] = '{1, 2, 16'h2222, 1, 1, 0, 2, 1,  0, 16'h2222, 0, 16'h1111, 1, 3'd3};

    reset_n = 1'b0;
    {write, reserve, flush} = '0;
    {addr1, addr2, addr_w, addr_r} = '0;
    data_w = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      @(negedge clk);
      addr1 = 2'(a);
      addr2 = 2'(3 - a);
      #1;
      chk($sformatf("rst d1[%0d]", a), 32'(data1), 32'h0);
      chk($sformatf("rst d2[%0d]", a), 32'(data2), 32'h0);
      chk($sformatf("rst b1[%0d]", a), 32'(busy1), 32'h0);
      chk($sformatf("rst b2[%0d]", a), 32'(busy2), 32'h0);
      chk($sformatf("rst cnt[%0d]", a), 32'(busy_count), 32'h0);
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      write = vecs[i].wr; addr_w = vecs[i].aw; data_w = vecs[i].dw;
      reserve = vecs[i].rs; addr_r = vecs[i].ar; flush = vecs[i].fl;
      addr1 = vecs[i].a1; addr2 = vecs[i].a2;
      sb.push_back(vecs[i]);
      #1 chk($sformatf("v%0d reserve_ok", i), 32'(reserve_ok), 32'(vecs[i].ok));
      @(posedge clk);
      #1 {write, reserve, flush} = '0;
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL v%0d scoreboard: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d data1", i), 32'(data1), 32'(e.d1));
        chk($sformatf("v%0d busy1", i), 32'(busy1), 32'(e.b1));
        chk($sformatf("v%0d data2", i), 32'(data2), 32'(e.d2));
        chk($sformatf("v%0d busy2", i), 32'(busy2), 32'(e.b2));
        chk($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(e.cnt));
      end
    end

    // R1 holds 0x1111 and is busy; busy set is {0,1,3}.
    @(negedge clk);
    write = 1'b1; addr_w = 2'd1; data_w = 16'hA5A5; addr1 = 2'd1;
    #1;
`ifdef RF_BYPASS_EN
    chk("fwd data1", 32'(data1), 32'hA5A5);
    chk("fwd busy1", 32'(busy1), 32'h0);
`else
    chk("nofwd data1", 32'(data1), 32'h1111);
    chk("nofwd busy1", 32'(busy1), 32'h1);
`endif
    @(posedge clk);
    #1 write = 1'b0;
    #1;
    chk("post-write data1", 32'(data1), 32'hA5A5);
    chk("post-write busy1", 32'(busy1), 32'h0);
    chk("post-write cnt", 32'(busy_count), 32'd2);

    // Async reset between edges with R0 and R3 pending.
    @(negedge clk);
    reserve = 1'b1; addr_r = 2'd0; addr1 = 2'd3; addr2 = 2'd2;
    #1 chk("pre-rst reserve_ok", 32'(reserve_ok), 32'h0);
    #1 reset_n = 1'b0;
    #1;
    chk("async rst data1", 32'(data1), 32'h0);
    chk("async rst busy1", 32'(busy1), 32'h0);
    chk("async rst data2", 32'(data2), 32'h0);
    chk("async rst cnt", 32'(busy_count), 32'h0);
    chk("async rst reserve_ok", 32'(reserve_ok), 32'h1);
    reserve = 1'b0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    addr1 = 2'd0;
    #1;
    chk("after rst busy1", 32'(busy1), 32'h0);
    chk("after rst data2", 32'(data2), 32'h0);
    chk("after rst cnt", 32'(busy_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
